uart_rx: RTL and testbench

- Serial receiver for the board UART link, at the far end of the transmit shift-register path.
- Samples an asynchronous 8N1 line clocked from CLOCK_50 (default 868 clocks/bit, about 57600 baud).
- Reassembles bytes LSB-first and presents them in a holding register with a full/ack handshake, plus framing and overrun flags for LEDR/debug.

---
 rtl/uart_rx_pkg.sv | 11 +
 rtl/uart_rx_sync.sv | 16 +
 rtl/uart_rx.sv | 91 +++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: link-wide UART defaults and receiver state encoding, shared with the transmitter.
package uart_rx_pkg;
    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS_DEF = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line plus a history flop for falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall_edge
);
    logic [2:0] sr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= 3'b111;
        else     sr <= {sr[1:0], rx_in};
    end
    assign rx_s = sr[1];
    assign fall_edge = sr[2] & ~sr[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with holding register, full/ack handshake, framing and overrun flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_full,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic rx_s;
    logic fall_edge;
    state_t state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] shreg;

    uart_rx_sync u_sync (
        .clk       (CLOCK_50),
        .rst       (reset),
        .rx_in     (rx_in),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_full   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            frame_err <= 1'b0;
            if (rx_ack && rx_full) begin
                rx_full <= 1'b0;
                overrun <= 1'b0;
            end
            case (state)
                IDLE: if (fall_edge) begin
                    state <= START;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                START: if (cnt == HALF_LAST) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= rx_s ? IDLE : DATA;
                    busy  <= ~rx_s;
                end
                DATA: if (cnt == BIT_LAST) begin
                    cnt   <= '0;
                    shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                    idx   <= idx + 1'b1;
                    if (idx == IDX_LAST) state <= STOP;
                end
                STOP: if (cnt == BIT_LAST) begin
                    cnt   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (rx_s) begin
                        rx_data <= shreg;
                        rx_full <= 1'b1;
                        // An ack on this same edge consumes the old byte, so no overrun.
                        if (rx_full && !rx_ack) overrun <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a byte-level model of the receiver.
module tb_uart_rx;
    localparam int CPB = 48;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in = 1'b1;
    logic rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic rx_full, frame_err, overrun, busy;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t0 = 0;
    int rise_cyc = -1;
    int fe_cnt = 0;
    logic full_prev = 1'b0;

    logic [7:0] exp_data = 8'h00;
    logic exp_full = 1'b0;
    logic exp_ovr = 1'b0;
    int exp_fe = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .rx_in     (rx_in),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (rx_full && !full_prev) rise_cyc = cyc;
        full_prev = rx_full;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // nb < 10 sends only the start bit and the first nb-1 data bits (partial frame).
    task automatic send(input logic [7:0] b, input logic stop, input logic ack_stop, input int nb);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < nb; i++) begin
            rx_in = bits[i];
            for (int j = 0; j < CPB; j++) begin
                if (ack_stop) rx_ack = (i == 9) && (cyc == t0 + 9 * CPB + HALF + 2);
                @(negedge clk);
            end
        end
        rx_ack = 1'b0;
        if (nb == 10) begin
            if (stop) begin
                if (exp_full && !ack_stop) exp_ovr = 1'b1;
                if (ack_stop) exp_ovr = 1'b0;
                exp_full = 1'b1;
                exp_data = b;
            end else begin
                exp_fe++;
            end
        end
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (exp_full) begin
            exp_full = 1'b0;
            exp_ovr = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        idle(2);
        chk({tag, ".data"}, 32'(rx_data), 32'(exp_data));
        chk({tag, ".full"}, 32'(rx_full), 32'(exp_full));
        chk({tag, ".ovr"}, 32'(overrun), 32'(exp_ovr));
        chk({tag, ".fe"}, 32'(fe_cnt), 32'(exp_fe));
    endtask

    initial begin
        int lat, want_lat;
        logic [7:0] rb;
        idle(3);
        chk("rst.data", 32'(rx_data), 0);
        chk("rst.full", 32'(rx_full), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.ovr", 32'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        rise_cyc = -1;
        send(8'h55, 1'b1, 1'b0, 10);
        lat = rise_cyc - t0;
        want_lat = 3 + 9 * CPB - 1 + HALF;
        chk("t1.latency", 32'(lat >= want_lat - 1 && lat <= want_lat + 1), 1);
        check_all("t1");
        ack();
        check_all("t1ack");

        @(negedge clk);
        rx_in = 1'b0;
        idle(HALF / 2);
        chk("t2.busy_hi", 32'(busy), 1);
        rx_in = 1'b1;
        idle(CPB);
        chk("t2.busy_lo", 32'(busy), 0);
        check_all("t2");

        send(8'hA3, 1'b0, 1'b0, 10);
        check_all("t3fe");
        idle(3 * CPB);
        chk("t3.break_idle", 32'(busy), 0);
        rx_in = 1'b1;
        idle(2 * CPB);
        chk("t3.no_retrig", 32'(busy), 0);
        send(8'h3C, 1'b1, 1'b0, 10);
        check_all("t3");

        ack();
        send(8'h12, 1'b1, 1'b0, 10);
        send(8'h34, 1'b1, 1'b0, 10);
        check_all("t4ovr");
        ack();
        check_all("t4ack");

        send(8'hF0, 1'b1, 1'b0, 5);
        idle(HALF);
        rst = 1'b1;
        idle(2);
        chk("t5.rst_busy", 32'(busy), 0);
        chk("t5.rst_full", 32'(rx_full), 0);
        chk("t5.rst_data", 32'(rx_data), 0);
        rx_in = 1'b1;
        exp_data = 8'h00;
        exp_full = 1'b0;
        exp_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(CPB);
        check_all("t5idle");
        send(8'h81, 1'b1, 1'b0, 10);
        check_all("t5");

        ack();
        send(8'h11, 1'b1, 1'b0, 10);
        send(8'h22, 1'b1, 1'b1, 10);
        check_all("t6");

        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom);
            if ($urandom_range(1, 0) == 1) ack();
            idle($urandom_range(CPB, 0));
            send(rb, $urandom_range(4, 0) != 0, $urandom_range(3, 0) == 0, 10);
            if (rx_in == 1'b0) begin
                idle(CPB);
                rx_in = 1'b1;
                idle(CPB);
            end
            check_all($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
